// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - packs a signed immediate into an I/S/B/U/J instruction word
// behind a single registered output stage, with saturating ok/error counters.
module imm_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        in_fire;
  logic        out_fire;
  logic [31:0] enc_instr;
  logic        enc_err;

  // Out-of-range values still pack their low bits; illegal formats pass in_base through.
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b1;
    case (in_fmt)
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_base[19:0]};
        enc_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
        enc_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1],
                     in_imm[11], in_base[6:0]};
        enc_err   = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_base[11:0]};
        enc_err   = |in_imm[11:0];
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
        enc_err   = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      default: begin
        enc_instr = in_base;
        enc_err   = 1'b1;
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_instr;
      out_err_d   = enc_err;
      if (enc_err) begin
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        if (ok_cnt_q != {CNT_W{1'b1}}) ok_cnt_d = ok_cnt_q + CNT_W'(1);
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_err_q   <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encode.sv
// tb/tb_imm_encode.sv - directed and round-trip checks for imm_encode,
// with a CNT_W=4 instance sharing the stimulus to exercise saturation.
module tb_imm_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [15:0] ok_cnt, err_cnt;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_instr;
  logic [3:0]  s_ok_cnt, s_err_cnt;

  int errors = 0;
  int checks = 0;

  imm_encode #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  imm_encode #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_err(s_out_err), .ok_cnt(s_ok_cnt), .err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base);
    in_valid = 1'b1;
    in_fmt   = f;
    in_imm   = imm;
    in_base  = base;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] decode(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd0:    decode = {{20{w[31]}}, w[31:20]};
      3'd1:    decode = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    decode = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    decode = {w[31:12], 12'h000};
      default: decode = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] legal_imm(input logic [2:0] f, input logic [31:0] r);
    case (f)
      3'd0, 3'd1: legal_imm = {{20{r[11]}}, r[11:0]};
      3'd2:       legal_imm = {{19{r[12]}}, r[12:1], 1'b0};
      3'd3:       legal_imm = {r[31:12], 12'h000};
      default:    legal_imm = {{11{r[20]}}, r[20:1], 1'b0};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_fmt = 3'd0; in_imm = '0; in_base = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_ok_cnt", 32'(ok_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send(3'd0, 32'hFFFFF800, 32'h00000013);
    chk("i_neg_valid", 32'(out_valid), 32'd1);
    chk("i_neg_instr", out_instr, 32'h80000013);
    chk("i_neg_err", 32'(out_err), 32'd0);
    chk("i_neg_ok", 32'(ok_cnt), 32'd1);

    send(3'd2, 32'h00000801, 32'h00000063);
    chk("b_odd_instr", out_instr, 32'h000000E3);
    chk("b_odd_err", 32'(out_err), 32'd1);
    chk("b_odd_errcnt", 32'(err_cnt), 32'd1);

    send(3'd2, 32'hFFFFF000, 32'h00000063);
    chk("b_min_instr", out_instr, 32'h80000063);
    chk("b_min_err", 32'(out_err), 32'd0);
    chk("b_min_ok", 32'(ok_cnt), 32'd2);

    send(3'd3, 32'h12345000, 32'h00000537);
    chk("u_instr", out_instr, 32'h12345537);
    chk("u_err", 32'(out_err), 32'd0);

    send(3'd4, 32'h00100000, 32'h0000006F);
    chk("j_ovf_instr", out_instr, 32'h8000006F);
    chk("j_ovf_err", 32'(out_err), 32'd1);

    send(3'd1, 32'hFFFFFFFC, 32'h00A12023);
    chk("s_instr", out_instr, 32'hFEA12E23);
    chk("s_err", 32'(out_err), 32'd0);

    send(3'd5, 32'h00000004, 32'hDEADBEEF);
    chk("badfmt_instr", out_instr, 32'hDEADBEEF);
    chk("badfmt_err", 32'(out_err), 32'd1);

    send(3'd0, 32'h00000800, 32'h00000013);
    chk("i_ovf_instr", out_instr, 32'h80000013);
    chk("i_ovf_err", 32'(out_err), 32'd1);
    chk("cnt_ok", 32'(ok_cnt), 32'd4);
    chk("cnt_err", 32'(err_cnt), 32'd4);

    idle_cycle();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: A is accepted, B waits through three stalled cycles.
    out_ready = 1'b0;
    send(3'd0, 32'd5, 32'h00000013);
    chk("bp_accept_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_fmt = 3'd0; in_imm = 32'd7; in_base = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_instr", out_instr, 32'h00500013);
      chk("bp_hold_ok", 32'(ok_cnt), 32'd5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_b_instr", out_instr, 32'h00700013);
    chk("bp_b_ok", 32'(ok_cnt), 32'd6);
    send(3'd0, 32'd9, 32'h00000013);
    chk("bp_c_instr", out_instr, 32'h00900013);
    chk("bp_c_ok", 32'(ok_cnt), 32'd7);
    idle_cycle();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

    // Fresh reset, then 17 legal requests: the 4-bit counter pins at 0xF.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      send(3'd0, 32'(i), 32'h00000013);
      if (i == 14) chk("sat_ok_14", 32'(s_ok_cnt), 32'd14);
    end
    chk("sat_ok_17", 32'(s_ok_cnt), 32'hF);
    chk("sat_err_17", 32'(s_err_cnt), 32'd0);
    chk("wide_ok_17", 32'(ok_cnt), 32'd17);

    // Reset asserted mid-stall discards the pending result.
    out_ready = 1'b0;
    send(3'd0, 32'd3, 32'h00000013);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("stall_pending", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", out_instr, 32'h0);
    chk("async_rst_ok", 32'(ok_cnt), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_ghost_valid", 32'(out_valid), 32'd0);
    end

    // Random legal immediates, one per cycle, decoded back from the packed word.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] imm;
      f   = 3'($urandom_range(0, 4));
      imm = legal_imm(f, $urandom);
      send(f, imm, $urandom);
      chk("rt_valid", 32'(out_valid), 32'd1);
      chk("rt_err", 32'(out_err), 32'd0);
      chk("rt_imm", decode(f, out_instr), imm);
    end
    chk("rt_ok_cnt", 32'(ok_cnt), 32'd40);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
